// File: rtl/trace_capture_fifo.sv
// Trace capture FIFO: first-word-fall-through buffer for core trace words with
// drop counting on overflow and a trap-triggered freeze of further capture.
module trace_capture_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     trace_valid,
   input  logic [35:0]              trace_data,
   input  logic                     trap,
   output logic                     out_valid,
   output logic [35:0]              out_data,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         overflow_count,
   output logic                     frozen
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {RUN, FROZEN} state_t;

   state_t        state;
   logic [35:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          pop;
   logic          push_req;
   logic          full;
   logic          push;
   logic          drop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      pop      = (level != '0) && out_ready;
      push_req = trace_valid && (state == RUN);
      full     = (level == (AW+1)'(DEPTH));
      push     = push_req && (!full || pop);
      drop     = push_req && full && !pop;
   end

   assign out_valid = (level != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign frozen    = (state == FROZEN);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         overflow_count <= '0;
         state          <= RUN;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            level <= level + 1'b1;
         else if (pop && !push)
            level <= level - 1'b1;
         if (drop && (overflow_count != '1))
            overflow_count <= overflow_count + 1'b1;
         case (state)
            RUN:     if (trap) state <= FROZEN;
            FROZEN:  state <= FROZEN;
            default: state <= RUN;
         endcase
      end
   end

   // Storage is not reset; only the pointers and level define valid contents.
   always_ff @(posedge clk) begin
      if (resetn && push) mem[wr_ptr] <= trace_data;
   end

endmodule

// File: tb/tb_trace_capture_fifo.sv
// Bench for trace_capture_fifo (DEPTH=4, CNT_W=3): directed scenarios with literal
// expectations plus random traffic checked every cycle against a queue model.
module tb_trace_capture_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned OVF_MAX = (1 << CNT_W) - 1;

   logic        clk = 1'b0;
   logic        resetn;
   logic        trace_valid;
   logic [35:0] trace_data;
   logic        trap;
   logic        out_valid;
   logic [35:0] out_data;
   logic        out_ready;
   logic [2:0]  level;
   logic [CNT_W-1:0] overflow_count;
   logic        frozen;

   int unsigned compared   = 0;
   int unsigned mismatched = 0;

   logic [35:0] q[$];
   int unsigned m_ovf = 0;
   bit          m_frz = 1'b0;
   bit          model_ok = 1'b0;

   trace_capture_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .trace_valid    (trace_valid),
      .trace_data     (trace_data),
      .trap           (trap),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .level          (level),
      .overflow_count (overflow_count),
      .frozen         (frozen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue bounded at DEPTH, updated from the inputs at each edge.
   always @(posedge clk) begin
      if (!resetn) begin
         q.delete();
         m_ovf    = 0;
         m_frz    = 1'b0;
         model_ok = 1'b1;
      end else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (trace_valid && !m_frz) begin
            if (q.size() < DEPTH) q.push_back(trace_data);
            else if (m_ovf < OVF_MAX) m_ovf++;
         end
         if (trap) m_frz = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("cmp_out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("cmp_out_data", 64'(out_data), (q.size() != 0) ? 64'(q[0]) : 64'd0);
         chk("cmp_level", 64'(level), 64'(q.size()));
         chk("cmp_overflow", 64'(overflow_count), 64'(m_ovf));
         chk("cmp_frozen", 64'(frozen), 64'(m_frz));
      end
   end

   task automatic tick(input logic tv, input logic [35:0] td, input logic tr, input logic rdy);
      trace_valid = tv;
      trace_data  = td;
      trap        = tr;
      out_ready   = rdy;
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick(1'b1, 36'hF_FFFF_FFFF, 1'b1, 1'b1);
      resetn = 1'b1;
   endtask

   initial begin
      resetn      = 1'b0;
      trace_valid = 1'b0;
      trace_data  = '0;
      trap        = 1'b0;
      out_ready   = 1'b0;
      @(negedge clk);
      do_reset();
      chk("reset_level", 64'(level), 64'd0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_data", 64'(out_data), 64'd0);
      chk("reset_overflow", 64'(overflow_count), 64'd0);
      chk("reset_frozen", 64'(frozen), 64'd0);

      // Basic order
      tick(1, 36'h1, 0, 0);
      tick(1, 36'h2, 0, 0);
      tick(1, 36'h3, 0, 0);
      chk("order_level", 64'(level), 64'd3);
      chk("order_model_level", 64'(q.size()), 64'd3);
      chk("order_head1", 64'(out_data), 64'h1);
      tick(0, '0, 0, 1);
      chk("order_head2", 64'(out_data), 64'h2);
      tick(0, '0, 0, 1);
      chk("order_head3", 64'(out_data), 64'h3);
      tick(0, '0, 0, 1);
      chk("order_empty_valid", 64'(out_valid), 64'd0);
      chk("order_empty_data", 64'(out_data), 64'd0);
      tick(0, '0, 0, 1);
      chk("pop_empty_level", 64'(level), 64'd0);

      // Overflow
      for (int i = 0; i < 6; i++) tick(1, 36'hA0 + 36'(i), 0, 0);
      chk("ovf_level", 64'(level), 64'd4);
      chk("ovf_count", 64'(overflow_count), 64'd2);
      chk("ovf_model_count", 64'(m_ovf), 64'd2);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain", 64'(out_data), 64'hA0 + 64'(i));
         tick(0, '0, 0, 1);
      end
      chk("ovf_drained", 64'(out_valid), 64'd0);

      // Full with simultaneous push and pop
      for (int i = 0; i < 4; i++) tick(1, 36'hB0 + 36'(i), 0, 0);
      tick(1, 36'hB4, 0, 1);
      chk("fullpop_level", 64'(level), 64'd4);
      chk("fullpop_ovf", 64'(overflow_count), 64'd2);
      for (int i = 1; i < 5; i++) begin
         chk("fullpop_drain", 64'(out_data), 64'hB0 + 64'(i));
         tick(0, '0, 0, 1);
      end

      // Wrap-around
      for (int i = 0; i < 10; i++) begin
         tick(1, 36'hC0 + 36'(i), 0, 0);
         chk("wrap_data", 64'(out_data), 64'hC0 + 64'(i));
         chk("wrap_level1", 64'(level), 64'd1);
         tick(0, '0, 0, 1);
      end
      chk("wrap_level0", 64'(level), 64'd0);

      // Random traffic, checked by the model every cycle
      for (int n = 0; n < 600; n++) begin
         resetn = ($urandom_range(0, 119) != 0);
         tick($urandom_range(0, 2) != 0, {4'($urandom), 32'($urandom)},
              $urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)));
      end
      resetn = 1'b1;

      // Trap freeze
      do_reset();
      tick(1, 36'hD0, 1, 0);
      chk("trap_frozen", 64'(frozen), 64'd1);
      tick(1, 36'hD1, 0, 0);
      tick(1, 36'hD2, 0, 0);
      chk("trap_level", 64'(level), 64'd1);
      chk("trap_data", 64'(out_data), 64'hD0);
      chk("trap_ovf", 64'(overflow_count), 64'd0);
      tick(0, '0, 0, 1);
      chk("trap_drained", 64'(out_valid), 64'd0);
      chk("trap_still_frozen", 64'(frozen), 64'd1);

      // Reset mid-operation
      do_reset();
      for (int i = 0; i < 9; i++) tick(1, 36'h90 + 36'(i), 0, 0);
      tick(0, '0, 0, 1);
      tick(0, '0, 1, 0);
      chk("pre_rst_level", 64'(level), 64'd3);
      chk("pre_rst_ovf", 64'(overflow_count), 64'd5);
      chk("pre_rst_frozen", 64'(frozen), 64'd1);
      resetn = 1'b0;
      tick(0, '0, 0, 0);
      resetn = 1'b1;
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_ovf", 64'(overflow_count), 64'd0);
      chk("rst_frozen", 64'(frozen), 64'd0);
      tick(1, 36'hE0, 0, 0);
      chk("post_rst_data", 64'(out_data), 64'hE0);
      chk("post_rst_level", 64'(level), 64'd1);
      tick(0, '0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
